// File: rtl/vga_pkg.sv
// Shared widths, colour constants and pattern-mode encoding for the VGA pattern path.
// Declarations only; there is no latency and no flow control.
package vga_pkg;

    localparam int N_WIDTH = 12;
    localparam int PIX_W   = 10;

    localparam logic [N_WIDTH-1:0] C_WHITE   = 12'hFFF;
    localparam logic [N_WIDTH-1:0] C_YELLOW  = 12'hFF0;
    localparam logic [N_WIDTH-1:0] C_CYAN    = 12'h0FF;
    localparam logic [N_WIDTH-1:0] C_GREEN   = 12'h0F0;
    localparam logic [N_WIDTH-1:0] C_MAGENTA = 12'hF0F;
    localparam logic [N_WIDTH-1:0] C_RED     = 12'hF00;
    localparam logic [N_WIDTH-1:0] C_BLUE    = 12'h00F;
    localparam logic [N_WIDTH-1:0] C_BLACK   = 12'h000;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    function automatic logic [N_WIDTH-1:0] bar_colour(input logic [2:0] idx);
        logic [N_WIDTH-1:0] c;
        case (idx)
            3'd0:    c = C_WHITE;
            3'd1:    c = C_YELLOW;
            3'd2:    c = C_CYAN;
            3'd3:    c = C_GREEN;
            3'd4:    c = C_MAGENTA;
            3'd5:    c = C_RED;
            3'd6:    c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position per axis, advanced once per unfrozen frame tick and clamped to the limits.
// Outputs are the position in effect this cycle (tick update included, zero latency); never stalls.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int BOX_STEP = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_freeze,
    input  logic [PIX_W-1:0] i_lim_x,
    input  logic [PIX_W-1:0] i_lim_y,
    output logic [PIX_W-1:0] o_box_x,
    output logic [PIX_W-1:0] o_box_y
);

    logic [PIX_W-1:0] x_q, x_d, y_q, y_d;
    logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;

    // Returns {direction, position}; direction 1 means moving towards zero.
    function automatic logic [PIX_W:0] axis_step(input logic [PIX_W-1:0] pos,
                                                 input logic             neg,
                                                 input logic [PIX_W-1:0] lim);
        logic [PIX_W:0] sum;
        sum = {1'b0, pos} + (PIX_W+1)'(BOX_STEP);
        if (!neg) begin
            if (sum >= {1'b0, lim}) return {1'b1, lim};
            return {1'b0, sum[PIX_W-1:0]};
        end
        if ({1'b0, pos} <= (PIX_W+1)'(BOX_STEP)) return {1'b0, {PIX_W{1'b0}}};
        return {1'b1, pos - PIX_W'(BOX_STEP)};
    endfunction

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (i_tick && !i_freeze) begin
            {dir_x_d, x_d} = axis_step(x_q, dir_x_q, i_lim_x);
            {dir_y_d, y_d} = axis_step(y_q, dir_y_q, i_lim_y);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign o_box_x = x_d;
    assign o_box_y = y_d;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: frame tick, mode latch, frame counter, pattern mux and output register.
// One cycle from pixel coordinates to o_rgb; no backpressure, a new pixel is accepted every cycle.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = 640,
    parameter int   V_ACTIVE  = 480,
    parameter int   BOX_SIZE  = 32,
    parameter int   BOX_STEP  = 2,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PIX_W-1:0]   i_pix_x,
    input  logic [PIX_W-1:0]   i_pix_y,
    input  logic               i_vid_on,
    input  logic               i_vsync,
    input  logic [1:0]         i_mode,
    input  logic               i_freeze,
    output logic [N_WIDTH-1:0] o_rgb,
    output logic [7:0]         o_frame_cnt,
    output logic [1:0]         o_mode
);

    localparam logic [PIX_W-1:0] LIM_X = PIX_W'(H_ACTIVE - BOX_SIZE);
    localparam logic [PIX_W-1:0] LIM_Y = PIX_W'(V_ACTIVE - BOX_SIZE);

    logic               vs_q;
    logic               frame_tick;
    mode_e              mode_q, mode_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [N_WIDTH-1:0] rgb_q, rgb_d;
    logic [PIX_W-1:0]   box_x, box_y;
    logic [5:0]         bar_div;
    logic [2:0]         bar_idx;
    logic               in_box;

    assign frame_tick = (i_vsync == VSYNC_POL) && (vs_q != VSYNC_POL);

    vga_box_mover #(
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_tick   (frame_tick),
        .i_freeze (i_freeze),
        .i_lim_x  (LIM_X),
        .i_lim_y  (LIM_Y),
        .o_box_x  (box_x),
        .o_box_y  (box_y)
    );

    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            mode_d = mode_e'(i_mode);
            if (!i_freeze) frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Pixels on the tick edge already see the new mode, count and box position.
    always_comb begin
        bar_div = i_pix_x[9:4] / 6'd5;
        bar_idx = (bar_div > 6'd7) ? 3'd7 : bar_div[2:0];
        in_box  = ({1'b0, i_pix_x} >= {1'b0, box_x}) &&
                  ({1'b0, i_pix_x} <  {1'b0, box_x} + (PIX_W+1)'(BOX_SIZE)) &&
                  ({1'b0, i_pix_y} >= {1'b0, box_y}) &&
                  ({1'b0, i_pix_y} <  {1'b0, box_y} + (PIX_W+1)'(BOX_SIZE));
        rgb_d   = C_BLACK;
        case (mode_d)
            MODE_BARS:  rgb_d = bar_colour(bar_idx);
            MODE_CHECK: rgb_d = (i_pix_x[5] ^ i_pix_y[5]) ? C_WHITE : C_BLACK;
            MODE_GRAD:  rgb_d = {i_pix_x[9:6], i_pix_y[8:5], frame_cnt_d[7:4]};
            MODE_BOX:   rgb_d = in_box ? C_RED : C_BLUE;
            default:    rgb_d = C_BLACK;
        endcase
        if (!i_vid_on) rgb_d = C_BLACK;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_q        <= ~VSYNC_POL;
            mode_q      <= MODE_BARS;
            frame_cnt_q <= '0;
            rgb_q       <= C_BLACK;
        end else begin
            vs_q        <= i_vsync;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            rgb_q       <= rgb_d;
        end
    end

    assign o_rgb       = rgb_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_mode      = mode_q;

endmodule
